// File: rtl/ddu_tx_framer.sv
// DDU transmit framer: buffers controller words and frames them for the TLK,
// with a minimum inter-frame gap, carrier-extend on underrun and statistics.
module ddu_tx_framer #(
    parameter int         DEPTH_LOG2 = 4,
    parameter int         IDLE_MIN   = 4,
    parameter logic [3:0] EOF_CODE   = 4'hE
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DIN,
    input  logic        DAV,
    input  logic        CLR_STAT,
    output logic [15:0] TXD,
    output logic        TX_EN,
    output logic        TX_ER,
    output logic        FULL,
    output logic        OVF,
    output logic [15:0] FRAMES,
    output logic [7:0]  UNDERRUNS
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int GW    = $clog2(IDLE_MIN + 2);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_EXTEND, S_GAP} state_t;

    logic [16:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr, rptr;
    logic [CW-1:0]         count, count_nxt;
    logic [16:0]           rd;
    logic                  empty, push, pop, take;
    state_t                state, state_nxt;
    logic [GW-1:0]         gap, gap_nxt;
    logic [15:0]           s_txd, s_txd_nxt;
    logic                  s_en, s_en_nxt, s_er, s_er_nxt;
    logic                  frame_inc, urun_inc;

    assign empty     = (count == '0);
    assign rd        = mem[rptr];
    assign push      = DAV && (!FULL || pop);
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign take      = !empty && (state != S_GAP);

    always_ff @(posedge CLK) begin
        if (push)
            mem[wptr] <= {DIN[15:12] == EOF_CODE, DIN};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            FULL  <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + DEPTH_LOG2'(1);
            if (pop)
                rptr <= rptr + DEPTH_LOG2'(1);
            count <= count_nxt;
            FULL  <= (count_nxt == CW'(DEPTH));
        end
    end

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap;
        pop       = 1'b0;
        s_txd_nxt = 16'h0000;
        s_en_nxt  = 1'b0;
        s_er_nxt  = 1'b0;
        frame_inc = 1'b0;
        urun_inc  = 1'b0;
        if (take) begin
            pop       = 1'b1;
            s_txd_nxt = rd[15:0];
            s_en_nxt  = 1'b1;
            state_nxt = S_SEND;
            if (rd[16]) begin
                frame_inc = 1'b1;
                if (IDLE_MIN == 0) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_GAP;
                    gap_nxt   = GW'(IDLE_MIN);
                end
            end
        end else begin
            unique case (state)
                S_SEND: begin
                    state_nxt = S_EXTEND;
                    urun_inc  = 1'b1;
                    s_txd_nxt = 16'hF7F7;
                    s_er_nxt  = 1'b1;
                end
                S_EXTEND: begin
                    s_txd_nxt = 16'hF7F7;
                    s_er_nxt  = 1'b1;
                end
                S_GAP: begin
                    gap_nxt = gap - GW'(1);
                    if (gap <= GW'(1))
                        state_nxt = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    // One staging register ahead of the output flops gives the
    // two-edge push-to-TXD latency while keeping all outputs registered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            gap   <= '0;
            s_txd <= 16'h0000;
            s_en  <= 1'b0;
            s_er  <= 1'b0;
            TXD   <= 16'h0000;
            TX_EN <= 1'b0;
            TX_ER <= 1'b0;
        end else begin
            state <= state_nxt;
            gap   <= gap_nxt;
            s_txd <= s_txd_nxt;
            s_en  <= s_en_nxt;
            s_er  <= s_er_nxt;
            TXD   <= s_txd;
            TX_EN <= s_en;
            TX_ER <= s_er;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVF       <= 1'b0;
            FRAMES    <= 16'h0000;
            UNDERRUNS <= 8'h00;
        end else if (CLR_STAT) begin
            OVF       <= 1'b0;
            FRAMES    <= 16'h0000;
            UNDERRUNS <= 8'h00;
        end else begin
            if (DAV && !push)
                OVF <= 1'b1;
            if (frame_inc)
                FRAMES <= FRAMES + 16'd1;
            if (urun_inc && UNDERRUNS != 8'hFF)
                UNDERRUNS <= UNDERRUNS + 8'd1;
        end
    end

endmodule

// File: tb/tb_ddu_tx_framer.sv
// Directed bench for ddu_tx_framer: framing, gap, underrun, overflow,
// mid-frame reset, FRAMES wrap and clear-vs-increment priority.
module tb_ddu_tx_framer;

    localparam logic [17:0] IDL = 18'h00000;
    localparam logic [17:0] EXT = 18'h2F7F7;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] DIN = 16'h0000;
    logic        CLR_STAT = 1'b0;
    logic        a_dav = 1'b0, b_dav = 1'b0, c_dav = 1'b0;

    logic [15:0] a_txd, b_txd, c_txd;
    logic        a_tx_en, b_tx_en, c_tx_en;
    logic        a_tx_er, b_tx_er, c_tx_er;
    logic        a_full, b_full, c_full;
    logic        a_ovf, b_ovf, c_ovf;
    logic [15:0] a_frames, b_frames, c_frames;
    logic [7:0]  a_urun, b_urun, c_urun;

    logic [17:0] alog [$];
    logic [17:0] blog [$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 CLK = ~CLK;

    ddu_tx_framer u_a (
        .CLK(CLK), .RST(RST), .DIN(DIN), .DAV(a_dav), .CLR_STAT(CLR_STAT),
        .TXD(a_txd), .TX_EN(a_tx_en), .TX_ER(a_tx_er), .FULL(a_full),
        .OVF(a_ovf), .FRAMES(a_frames), .UNDERRUNS(a_urun)
    );

    ddu_tx_framer #(.IDLE_MIN(30)) u_b (
        .CLK(CLK), .RST(RST), .DIN(DIN), .DAV(b_dav), .CLR_STAT(CLR_STAT),
        .TXD(b_txd), .TX_EN(b_tx_en), .TX_ER(b_tx_er), .FULL(b_full),
        .OVF(b_ovf), .FRAMES(b_frames), .UNDERRUNS(b_urun)
    );

    ddu_tx_framer #(.IDLE_MIN(0)) u_c (
        .CLK(CLK), .RST(RST), .DIN(DIN), .DAV(c_dav), .CLR_STAT(CLR_STAT),
        .TXD(c_txd), .TX_EN(c_tx_en), .TX_ER(c_tx_er), .FULL(c_full),
        .OVF(c_ovf), .FRAMES(c_frames), .UNDERRUNS(c_urun)
    );

    function automatic logic [17:0] w(input logic [15:0] d);
        return {2'b01, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        alog.push_back({a_tx_er, a_tx_en, a_txd});
        blog.push_back({b_tx_er, b_tx_en, b_txd});
    endtask

    task automatic reset_all();
        a_dav = 1'b0;
        b_dav = 1'b0;
        c_dav = 1'b0;
        CLR_STAT = 1'b0;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        tick();
        alog.delete();
        blog.delete();
    endtask

    initial begin
        logic [17:0] e1 [8];
        logic [17:0] e2 [12];
        logic [17:0] e3 [10];
        logic [17:0] e4 [6];
        logic [15:0] words [$];
        int          idle;

        // Reset state and a simple 3-word frame
        reset_all();
        chk("rst_txd", a_txd, 0);
        chk("rst_flags", {a_tx_en, a_tx_er, a_full, a_ovf}, 0);
        chk("rst_stats", {a_frames, a_urun}, 0);
        DIN = 16'h1234; a_dav = 1'b1; tick();
        DIN = 16'h5678; tick();
        DIN = 16'hE001; tick();
        a_dav = 1'b0;
        repeat (5) tick();
        e1 = '{IDL, IDL, w(16'h1234), w(16'h5678), w(16'hE001), IDL, IDL, IDL};
        for (int i = 0; i < 8; i++)
            chk($sformatf("t1_e%0d", i), 32'(alog[i]), 32'(e1[i]));
        chk("t1_frames", a_frames, 1);

        // Two back-to-back frames separated by the 4-cycle gap
        reset_all();
        a_dav = 1'b1;
        DIN = 16'h2001; tick();
        DIN = 16'hE011; tick();
        DIN = 16'h2002; tick();
        DIN = 16'hE012; tick();
        a_dav = 1'b0;
        repeat (8) tick();
        e2 = '{IDL, IDL, w(16'h2001), w(16'hE011), IDL, IDL, IDL, IDL,
               w(16'h2002), w(16'hE012), IDL, IDL};
        for (int i = 0; i < 12; i++)
            chk($sformatf("t2_e%0d", i), 32'(alog[i]), 32'(e2[i]));
        chk("t2_frames", a_frames, 2);

        // Underrun: EOF word arrives 5 cycles after the first word
        reset_all();
        DIN = 16'h1111; a_dav = 1'b1; tick();
        a_dav = 1'b0;
        repeat (4) tick();
        DIN = 16'hE002; a_dav = 1'b1; tick();
        a_dav = 1'b0;
        repeat (4) tick();
        e3 = '{IDL, IDL, w(16'h1111), EXT, EXT, EXT, EXT, w(16'hE002),
               IDL, IDL};
        for (int i = 0; i < 10; i++)
            chk($sformatf("t3_e%0d", i), 32'(alog[i]), 32'(e3[i]));
        chk("t3_urun", a_urun, 1);
        chk("t3_frames", a_frames, 1);

        // Reset in the middle of a 4-word frame
        reset_all();
        a_dav = 1'b1;
        DIN = 16'h3001; tick();
        DIN = 16'h3002; tick();
        DIN = 16'h3003; tick();
        DIN = 16'hE004; tick();
        a_dav = 1'b0;
        chk("t4_w2", 32'(alog[3]), 32'(w(16'h3002)));
        RST = 1'b1;
        #1;
        chk("t4_rst_out", {a_tx_en, a_txd}, 0);
        chk("t4_rst_frames", a_frames, 0);
        tick();
        RST = 1'b0;
        alog.delete();
        a_dav = 1'b1;
        DIN = 16'h4001; tick();
        DIN = 16'hE005; tick();
        a_dav = 1'b0;
        repeat (4) tick();
        e4 = '{IDL, IDL, w(16'h4001), w(16'hE005), IDL, IDL};
        for (int i = 0; i < 6; i++)
            chk($sformatf("t4_e%0d", i), 32'(alog[i]), 32'(e4[i]));
        chk("t4_frames", a_frames, 1);

        // Overflow while the long-gap instance sits in GAP
        reset_all();
        DIN = 16'hE000; b_dav = 1'b1; tick();
        for (int i = 0; i < 17; i++) begin
            DIN = 16'h0100 + 16'(i);
            tick();
            if (i == 14) chk("t5_full15", b_full, 0);
            if (i == 15) chk("t5_full16", {b_full, b_ovf}, 2'b10);
            if (i == 16) chk("t5_ovf", {b_full, b_ovf}, 2'b11);
        end
        b_dav = 1'b0;
        repeat (50) tick();
        foreach (blog[i])
            if (blog[i][16]) words.push_back(blog[i][15:0]);
        chk("t5_nwords", words.size(), 17);
        if (words.size() == 17) begin
            chk("t5_w0", words[0], 16'hE000);
            for (int i = 1; i < 17; i++)
                chk($sformatf("t5_w%0d", i), words[i], 16'h0100 + 16'(i - 1));
        end
        chk("t5_urun", b_urun, 1);
        CLR_STAT = 1'b1; tick();
        CLR_STAT = 1'b0;
        chk("t5_clr", {b_ovf, b_frames, b_urun}, 0);

        // FRAMES wrap with zero gap, then clear against an EOF pop
        reset_all();
        DIN = 16'hE000; c_dav = 1'b1;
        idle = 0;
        for (int i = 0; i < 65535; i++) begin
            tick();
            if (i >= 2 && !c_tx_en) idle++;
        end
        c_dav = 1'b0;
        repeat (4) tick();
        chk("t6_nogap", idle, 0);
        chk("t6_ffff", c_frames, 16'hFFFF);
        chk("t6_urun", c_urun, 0);
        c_dav = 1'b1; tick();
        c_dav = 1'b0;
        repeat (4) tick();
        chk("t6_wrap", c_frames, 16'h0000);
        c_dav = 1'b1;
        tick();
        tick();
        chk("t6_inc", c_frames, 1);
        CLR_STAT = 1'b1;
        tick();
        chk("t6_clrwin", c_frames, 0);
        CLR_STAT = 1'b0;
        c_dav = 1'b0;
        tick();
        chk("t6_after", c_frames, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ddu_tx_framer.md
Name: ddu_tx_framer

Overview:
- Output stage between the data-flow controller (16-bit DOUT words plus DAV push) and the TLK gigabit transmitter registers toward the DDU.
- Buffers event words in a small FIFO and delimits frames, detecting the last word of each event by its code.
- Enforces a minimum idle gap between frames and signals underrun as TLK carrier-extend.
- Keeps frame, underrun and overflow statistics for JTAG status readout.

Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 words.
- IDLE_MIN, 4: minimum idle cycles between the last word of one frame and the first word of the next; 0 is legal.
- EOF_CODE, 4'hE: value of DIN[15:12] that marks the last word of an event.

Ports:
- CLK  in  1  clkddu domain clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high; clears FIFO, state, counters and outputs.
- DIN  in  16  event word from the controller.
- DAV  in  1  push strobe; DIN is valid when DAV=1.
- TXD  out  16  word to the TLK data register.
- TX_EN  out  1  TLK transmit enable.
- TX_ER  out  1  TLK error / carrier-extend.
- FULL  out  1  FIFO holds 2**DEPTH_LOG2 words.
- OVF  out  1  sticky: a push was dropped.
- FRAMES  out  16  frames completed; wraps FFFF->0000.
- UNDERRUNS  out  8  mid-frame empty events; saturates at FF.
- CLR_STAT  in  1  synchronous clear of OVF, FRAMES and UNDERRUNS.

Behaviour:
- Reset values:
  - TXD=0, TX_EN=0, TX_ER=0, FULL=0, OVF=0, FRAMES=0, UNDERRUNS=0.
  - FIFO empty; state IDLE; gap counter 0. No gap is owed after reset.
- FIFO write:
  - DAV=1 and FIFO not full: {DIN} is stored, with eof flag = (DIN[15:12]==EOF_CODE).
  - DAV=1 with FULL=1 and no pop in the same cycle: word dropped; OVF<=1.
  - Push and pop in the same cycle when full: push accepted; occupancy is unchanged.
- Occupancy counter is DEPTH_LOG2+1 bits; read and write pointers wrap modulo depth.
- All outputs are registered. Latency: a word pushed at edge k into an empty FIFO, in state IDLE, appears on TXD with TX_EN=1 after edge k+2.
- State machine:
  - IDLE:
    - Outputs TX_EN=0, TX_ER=0, TXD=0.
    - If the FIFO is non-empty, pop and go to SEND.
  - SEND:
    - Each cycle with the FIFO non-empty: pop one word and drive TXD=word, TX_EN=1, TX_ER=0.
    - If the popped word has eof=1: FRAMES+1. Then go to GAP with the counter loaded to IDLE_MIN, or go to IDLE if IDLE_MIN=0.
    - If the FIFO is empty before EOF: go to EXTEND.
  - EXTEND (underrun):
    - Drive TX_EN=0, TX_ER=1, TXD=16'hF7F7.
    - UNDERRUNS+1 once on entry, saturating.
    - Return to SEND on the first cycle the FIFO is non-empty. That word is popped in the same cycle as the exit.
  - GAP:
    - Outputs as in IDLE; the counter decrements each cycle.
    - At 1, go to IDLE. The next frame's first word follows exactly IDLE_MIN idle cycles after the EOF word.
    - Pushes during GAP are accepted normally.
- Back-to-back frames already in the FIFO are separated by exactly IDLE_MIN idle cycles.
- CLR_STAT coinciding with an increment: clear wins.
- RST asserted mid-frame:
  - Outputs go to their reset values immediately; buffered words are lost; no EOF is emitted.
  - The first frame after reset starts clean, with no gap.
- A word with eof=1 arriving as the first word of a frame is a one-word frame: FRAMES+1, then GAP.

Test Plan:
- Reset, then push 3 words 0x1234, 0x5678, 0xE001 on consecutive cycles -> TXD shows the same three words starting 2 cycles after the first push; TX_EN=1 for exactly 3 cycles; FRAMES=1.
- Two frames of 2 words each (second word 0xE0xx) pushed back-to-back, IDLE_MIN=4 -> exactly 4 cycles with TX_EN=0 between the frames; FRAMES=2.
- Push 0x1111, wait 5 cycles, then push 0xE002 -> after 0x1111, EXTEND holds for 4 cycles with TX_ER=1 and TXD=F7F7; then 0xE002 is sent with TX_EN=1; UNDERRUNS=1.
- Push 17 non-EOF words with output stalled in GAP (DEPTH_LOG2=4) -> FULL=1 after the 16th word; the 17th word is dropped; OVF=1. Subsequent output contains only the first 16 words in order.
- Assert RST during word 2 of a 4-word frame -> the next cycle shows TX_EN=0 and TXD=0. A new frame pushed after release transmits 2 cycles later with no gap; FRAMES unchanged by the aborted frame.
- Preload FRAMES to FFFF by sending 65535 one-word frames 0xE000, then send one more -> FRAMES=0000. Then CLR_STAT with a simultaneous EOF -> FRAMES=0.
